uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Bit-timing and oversampling front end of the UART receiver. Counts oversampling clock edges within each bit period and bit periods within a frame. Takes a 3-sample majority vote around mid-bit and presents the result as `sampled_bit` with a one-cycle `sample_valid` strobe. Directly feeds the RX deserializer and the RX parity checker (`sampled_bit`). Exposes `edge_cnt`/`bit_cnt` to the RX FSM.

## Interface
- `PRESCALE_W`, default 6: width of the prescale and edge counter. Max oversampling is 2^PRESCALE_W − 1.
- `BIT_CNT_W`, default 4: width of the bit counter.
- `clk_RX` input, 1: receiver oversampling clock. Single clock domain.
- `rst` input, 1: asynchronous, active-low reset.
- `RX_IN` input, 1: serial line, idle high.
- `Prescale` input, PRESCALE_W: oversampling ratio. Legal: even values ≥ 6 (8, 16, 32 are the system values).
- `cnt_en` input, 1: from the RX FSM. High = counting, low = counters held at zero.
- `sampled_bit` output, 1: majority-voted bit value.
- `sample_valid` output, 1: one-cycle strobe that `sampled_bit` was updated.
- `bit_done` output, 1: one-cycle strobe at the end of each bit period.
- `edge_cnt` output, PRESCALE_W: current edge position within the bit, 0..P−1.
- `bit_cnt` output, BIT_CNT_W: bit index within the frame.

## Operation
- **Prescale capture:** `Prescale` is latched into `P` on the clock edge where `cnt_en` rises (0→1). Changes to `Prescale` while `cnt_en` stays high are ignored. Define `mid = P >> 1`.
- **Edge counter:** while `cnt_en` is high, `edge_cnt` increments every cycle. At `P−1` it wraps to 0.
- **Bit counter:** `bit_cnt` increments on each wrap, modulo 2^BIT_CNT_W. It never saturates.
- **Idle clear:** `cnt_en` low → `edge_cnt`, `bit_cnt`, the sample shift register and both strobes clear on the next edge. `sampled_bit` holds its value.
- **Sampling:** the line is captured at `edge_cnt` = mid−1 and mid into a 2-bit register.
  - On the edge where `edge_cnt` = mid+1, `sampled_bit` ← majority(s0, s1, line) and `sample_valid` ← 1.
  - `sample_valid` clears on the following edge.
- **Bit end:** `bit_done` ← 1 on the edge where `edge_cnt` = P−1 with `cnt_en` high. It clears on the next edge.
- **Illegal Prescale:** P < 6 or odd P is illegal. No protection beyond the wrap; outputs are unspecified.

## Timing
- **Reset values:** `edge_cnt` = 0, `bit_cnt` = 0, `sampled_bit` = 1, `sample_valid` = 0, `bit_done` = 0, sample register = 2'b11.
- **`cnt_en` rise:** the first cycle with `cnt_en` high has `edge_cnt` = 0. The count becomes 1 after the first edge.
- **Strobe timing:** `sample_valid` is high exactly during the cycle where `edge_cnt` = mid+2. `bit_done` is high during the cycle where `edge_cnt` = 0 of the next bit.
- **Valid data window:** `sampled_bit` is stable from `sample_valid` until the next bit's mid+1 edge. Consumers read it in the strobe cycle or later.
- **`cnt_en` drop mid-bit:** an in-progress vote is discarded. No `sample_valid`, no `bit_done`.
- **Simultaneous events:** `cnt_en` falling on the same edge a strobe would fire suppresses that strobe.
- **Reset mid-operation:** all state clears asynchronously. The first edge after reset release behaves as idle.
- **All outputs are registered.** No combinational path from `RX_IN` to any output.

## Configuration
- Macro `UART_RX_SAMPLER_SYNC_EN`.
- **Defined:** `RX_IN` passes through a 2-flop synchronizer reset to 1. The sampled line is the synchronizer output, so line-to-`sampled_bit` latency grows by 2 cycles. Counter and strobe timing are unchanged relative to `edge_cnt`.
- **Undefined:** `RX_IN` is used directly. The upstream pad logic guarantees synchronization.

## Structure
- **Shared package `uart_rx_pkg`:**
  - `PRESCALE_W` and `BIT_CNT_W` defaults.
  - Minimum-prescale constant `MIN_PRESCALE` = 6.
  - `maj3` function, also used by the start-glitch check.
- **Sub-module `rx_edge_bit_counter`:** holds the Prescale latch, `edge_cnt`, `bit_cnt` and `bit_done`. The top adds the synchronizer, sample register, vote and `sample_valid`.

## Test plan
- **Nominal bit:** Prescale=8, `RX_IN`=0 constant, `cnt_en` rise → `sample_valid` in the cycle `edge_cnt`=6, with `sampled_bit`=0. `bit_done` in the cycle `edge_cnt` returns to 0, with `bit_cnt`=1.
- **Majority vote:** Prescale=16, line 1,0,1 at `edge_cnt` 7,8,9 → `sampled_bit`=1. Line 0,1,0 → `sampled_bit`=0.
- **Full frame:** Prescale=32, 10-bit frame 0x55 with start/stop bits → 10 `sample_valid` strobes, spaced 32 cycles apart, carrying LSB-first data. `bit_cnt` reaches 10.
- **Abort and wrap:** `cnt_en` dropped at `edge_cnt`=4 with Prescale=8 → no strobe. Counters are 0 next cycle and `sampled_bit` is unchanged. Separately, 16 bit periods → `bit_cnt` wraps to 0.
- **Prescale change and reset:** Prescale changed from 8 to 16 mid-frame → period stays 8 until `cnt_en` re-rises. `rst` asserted mid-bit → all outputs at reset values immediately.
- **Synchronizer build:** with `UART_RX_SAMPLER_SYNC_EN` defined, the vote reflects the line 2 cycles earlier. A 1-cycle glitch at `edge_cnt`=mid is outvoted.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: default widths, the minimum
// legal oversampling ratio and the 3-input majority vote.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W_DEF = 6;
  localparam int unsigned BIT_CNT_W_DEF  = 4;
  localparam int unsigned MIN_PRESCALE   = 6;

  // Majority of three samples; also used by the start-glitch check.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Bit-timing counters for the UART receiver: latches the oversampling ratio
// when counting starts, counts oversampling edges within a bit and bits
// within a frame, and strobes at the end of each bit period.
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cnt_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic                  o_bit_done,
  output logic [PRESCALE_W-1:0] o_mid
);

  logic                  r_cnt_en_q;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_bit_done;

  logic                  w_rise;
  logic [PRESCALE_W-1:0] w_p_eff;
  logic                  w_wrap;

  // On the enabling edge the incoming ratio is already the one in force, so
  // the wrap compare and mid point never see a stale latched value.
  always_comb begin
    w_rise  = i_cnt_en & ~r_cnt_en_q;
    w_p_eff = w_rise ? i_prescale : r_prescale;
    w_wrap  = (r_edge_cnt == (w_p_eff - PRESCALE_W'(1)));
  end

  assign o_mid      = w_p_eff >> 1;
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_bit_done = r_bit_done;

  // Track the enable and capture the oversampling ratio on its rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_en_q <= 1'b0;
      r_prescale <= '0;
    end else begin
      r_cnt_en_q <= i_cnt_en;
      if (w_rise) begin
        r_prescale <= i_prescale;
      end
    end
  end

  // Edge/bit counters and end-of-bit strobe; all held at zero while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_bit_done <= 1'b0;
    end else if (!i_cnt_en) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_bit_done <= 1'b0;
    end else begin
      r_bit_done <= w_wrap;
      if (w_wrap) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive oversampling front end: bit-timing counters plus a 3-sample
// majority vote around mid-bit, presented as sampled_bit with a one-cycle
// sample_valid strobe.
// Build option: define UART_RX_SAMPLER_SYNC_EN to pass RX_IN through a
// 2-flop synchronizer (reset to 1) before sampling.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  clk_RX,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  cnt_en,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  bit_done,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  logic                  w_line;
  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [PRESCALE_W-1:0] w_mid;

  logic [1:0]            r_samp;
  logic                  r_sampled_bit;
  logic                  r_sample_valid;

`ifdef UART_RX_SAMPLER_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], RX_IN};
    end
  end

  assign w_line = r_sync[1];
`else
  assign w_line = RX_IN;
`endif

  rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_counter (
    .i_clk      (clk_RX),
    .i_rst_n    (rst),
    .i_cnt_en   (cnt_en),
    .i_prescale (Prescale),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (bit_cnt),
    .o_bit_done (bit_done),
    .o_mid      (w_mid)
  );

  assign edge_cnt     = w_edge_cnt;
  assign sampled_bit  = r_sampled_bit;
  assign sample_valid = r_sample_valid;

  // Capture the line at mid-1 and mid, then vote with the mid+1 sample.
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      r_samp         <= 2'b11;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
    end else if (!cnt_en) begin
      r_samp         <= 2'b11;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_edge_cnt == (w_mid - PRESCALE_W'(1))) begin
        r_samp[0] <= w_line;
      end
      if (w_edge_cnt == w_mid) begin
        r_samp[1] <= w_line;
      end
      if (w_edge_cnt == (w_mid + PRESCALE_W'(1))) begin
        r_sampled_bit  <= maj3(r_samp[0], r_samp[1], w_line);
        r_sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed scenarios plus random
// runs, every cycle compared against an arithmetic model of the bit timing.
module tb_uart_rx_sampler;

  localparam int PW   = 6;
  localparam int BW   = 4;
  localparam int MAXC = 6000;
`ifdef UART_RX_SAMPLER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic          clk_RX = 1'b0;
  logic          rst    = 1'b1;
  logic          RX_IN  = 1'b1;
  logic          cnt_en = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);
  logic          sampled_bit;
  logic          sample_valid;
  logic          bit_done;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;

  always #5 clk_RX = ~clk_RX;

  uart_rx_sampler #(
    .PRESCALE_W (PW),
    .BIT_CNT_W  (BW)
  ) dut (
    .clk_RX       (clk_RX),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .cnt_en       (cnt_en),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .bit_done     (bit_done),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt)
  );

  // Input history per cycle; cycle c's inputs are sampled at the edge ending it.
  bit en_h  [MAXC];
  bit rx_h  [MAXC];
  int pre_h [MAXC];
  int cyc;
  int rst_rel;
  int nvec;
  int nerr;
  bit exp_samp;
  bit obsq[$];
  int obsc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    nvec++;
    assert (obs === 32'(exp)) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Line value seen by the voter during cycle c.
  function automatic int line_at(input int c);
    if (SYNC) return (c - 2 >= rst_rel) ? int'(rx_h[c-2]) : 1;
    return int'(rx_h[c]);
  endfunction

  // Expected outputs from the length of the current enable run.
  task automatic model_check();
    int k, i, p, r, s, ee, eb;
    bit ev, ed;
    k = 0;
    i = cyc - 1;
    while (i >= rst_rel && en_h[i]) begin
      k++;
      i--;
    end
    ee = 0; eb = 0; ev = 0; ed = 0;
    if (k > 0) begin
      p  = pre_h[cyc-k];
      r  = k % p;
      ee = r;
      eb = (k / p) % (1 << BW);
      ed = (r == 0);
      ev = (r == p / 2 + 2);
      if (ev) begin
        s = line_at(cyc-3) + line_at(cyc-2) + line_at(cyc-1);
        exp_samp = (s >= 2);
      end
    end
    chk("edge_cnt", edge_cnt, ee);
    chk("bit_cnt", bit_cnt, eb);
    chk("bit_done", bit_done, ed);
    chk("sample_valid", sample_valid, ev);
    chk("sampled_bit", sampled_bit, exp_samp);
  endtask

  task automatic drive(input bit en, input bit rx, input int pre);
    cnt_en   = en;
    RX_IN    = rx;
    Prescale = PW'(pre);
  endtask

  task automatic tick();
    if (cyc >= MAXC - 2) begin
      $display("FAIL cycle_budget: observed %0d expected < %0d", cyc, MAXC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    en_h[cyc]  = cnt_en;
    rx_h[cyc]  = RX_IN;
    pre_h[cyc] = int'(Prescale);
    @(posedge clk_RX);
    cyc++;
    #1;
    model_check();
    if (sample_valid === 1'b1) begin
      obsq.push_back(sampled_bit);
      obsc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_sampled_bit", sampled_bit, 1);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_bit_done", bit_done, 0);
    @(posedge clk_RX);
    cyc++;
    #1;
    rst      = 1'b1;
    rst_rel  = cyc;
    exp_samp = 1'b1;
  endtask

  task automatic idle(input int n, input int pre);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, pre);
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit frame [10];
    bit saved;
    int p, len, hold;
    bit rx;
    logic [7:0] byte_v;
    cyc = 0; rst_rel = 0; nvec = 0; nerr = 0; exp_samp = 1'b1;
    #2;
    do_reset();

    // Nominal bit: P=8, line low.
    idle(2, 8);
    obsq.delete(); obsc.delete();
    for (int j = 0; j < 12; j++) begin
      drive(1'b1, 1'b0, 8);
      tick();
    end
    chk("nom_strobes", obsq.size(), 1);
    if (obsq.size() > 0) chk("nom_value", obsq[0], 0);
    idle(2, 8);

    // Majority vote: P=16, 1,0,1 then 0,1,0 at edges 7,8,9.
    obsq.delete(); obsc.delete();
    for (int j = 0; j < 32; j++) begin
      int e;
      e = j % 16;
      if (j < 16) rx = (e == 7 || e == 9) ? 1'b1 : 1'b0;
      else        rx = (e == 8) ? 1'b1 : 1'b0;
      drive(1'b1, rx, 16);
      tick();
    end
    chk("maj_strobes", obsq.size(), 2);
    if (obsq.size() == 2) begin
      chk("maj_101", obsq[0], 1);
      chk("maj_010", obsq[1], 0);
    end
    idle(2, 16);

    // Full frame 0x55 at P=32: start, 8 data LSB first, stop.
    byte_v = 8'h55;
    frame[0] = 1'b0;
    for (int b = 0; b < 8; b++) frame[b+1] = byte_v[b];
    frame[9] = 1'b1;
    obsq.delete(); obsc.delete();
    for (int j = 0; j < 320; j++) begin
      drive(1'b1, frame[j/32], 32);
      tick();
    end
    chk("frame_bit_cnt", bit_cnt, 10);
    chk("frame_strobes", obsq.size(), 10);
    if (obsq.size() == 10) begin
      byte_v = '0;
      for (int b = 0; b < 8; b++) byte_v[b] = obsq[b+1];
      chk("frame_start", obsq[0], 0);
      chk("frame_data", byte_v, 8'h55);
      chk("frame_stop", obsq[9], 1);
      for (int b = 1; b < 10; b++) chk("frame_spacing", obsc[b] - obsc[b-1], 32);
    end
    idle(2, 32);

    // Abort at edge_cnt=4 with P=8.
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b0, 8);
      tick();
    end
    saved = exp_samp;
    obsq.delete(); obsc.delete();
    drive(1'b0, 1'b0, 8);
    tick();
    chk("abort_edge", edge_cnt, 0);
    chk("abort_hold", sampled_bit, saved);
    idle(6, 8);
    chk("abort_no_strobe", obsq.size(), 0);

    // Bit counter wraps after 16 periods at P=6.
    for (int j = 0; j < 96; j++) begin
      drive(1'b1, 1'b1, 6);
      tick();
    end
    chk("wrap_bit_cnt", bit_cnt, 0);
    chk("wrap_bit_done", bit_done, 1);
    idle(2, 6);

    // Prescale change mid-frame is ignored until the next enable.
    for (int j = 0; j < 24; j++) begin
      drive(1'b1, j[3], (j < 10) ? 8 : 16);
      tick();
    end
    chk("pchg_bit_cnt", bit_cnt, 3);
    idle(2, 16);
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 1'b0, 16);
      tick();
    end
    chk("pchg_new_period", bit_cnt, 1);
    idle(2, 16);

    // Single-cycle glitch at mid is outvoted.
    obsq.delete(); obsc.delete();
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, (j == 8) ? 1'b0 : 1'b1, 16);
      tick();
    end
    chk("glitch_strobes", obsq.size(), 1);
    if (obsq.size() > 0) chk("glitch_value", obsq[0], 1);
    idle(1, 16);

    // Reset mid-bit.
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 1'b0, 8);
      tick();
    end
    do_reset();
    idle(2, 8);

    // Random runs with random line data, ratios and occasional disturbances.
    hold = 0;
    rx = 1'b1;
    for (int seg = 0; seg < 40; seg++) begin
      p   = uart_rx_pkg::MIN_PRESCALE + 2 * $urandom_range(0, 7);
      if ($urandom_range(0, 4) == 0) p = 32;
      len = $urandom_range(1, 90);
      for (int j = 0; j < len; j++) begin
        if (hold == 0) begin
          rx   = $urandom_range(0, 1);
          hold = $urandom_range(1, 12);
        end
        hold--;
        if (j > 0 && $urandom_range(0, 15) == 0)
          Prescale = PW'(uart_rx_pkg::MIN_PRESCALE + 2 * $urandom_range(0, 7));
        drive(1'b1, rx, (j == 0) ? p : int'(Prescale));
        tick();
      end
      if ($urandom_range(0, 9) == 0) do_reset();
      idle($urandom_range(1, 3), p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
